// File: rtl/timer_dev_if.sv
// CPU-side register bus of the countdown timer: word select, byte-enabled write, read data and interrupt line.
interface timer_dev_if;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  modport master (output addr, output we, output be, output din, input dout, input irq);
  modport slave  (input addr, input we, input be, input din, output dout, output irq);
endinterface

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer (CTRL/PRESET/COUNT) with a maskable pending interrupt.
// Define TIMER_AUTORELOAD_EN to let MODE=01 reload PRESET after each terminal count.
module timer_dev (
  input  logic       clk,
  input  logic       rst,
  timer_dev_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic        pend_q, pend_d;
  logic        irq_q, irq_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;

  logic        wr_ctrl_s;
  logic        wr_preset_s;
  logic        auto_s;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be_v);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be_v[i]) begin
        res[8*i +: 8] = new_v[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_v[8*i +: 8];
      end
    end
    return res;
  endfunction

  assign wr_ctrl_s   = bus.we && (bus.addr == 2'd0) && bus.be[0];
  assign wr_preset_s = bus.we && (bus.addr == 2'd1);

`ifdef TIMER_AUTORELOAD_EN
  assign auto_s = (mode_q == 2'b01);
`else
  assign auto_s = 1'b0;
`endif

  // Sequencer: idle / load preset / count down / one-cycle terminal state.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (en_q) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en_q) begin
          state_d = ST_IDLE;
        end else if (count_q <= 32'd1) begin
          count_d = 32'd0;
          state_d = ST_INT;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      ST_INT: begin
        if (auto_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register file next state; a terminal count beats a same-cycle PEND clear, a CTRL write beats the one-shot EN clear.
  always_comb begin
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    pend_d   = pend_q;
    preset_d = preset_q;
    if (wr_ctrl_s) begin
      en_d   = bus.din[0];
      mode_d = bus.din[2:1];
      im_d   = bus.din[3];
    end else if ((state_q == ST_INT) && !auto_s) begin
      en_d = 1'b0;
    end else begin
      en_d = en_q;
    end
    if (state_q == ST_INT) begin
      pend_d = 1'b1;
    end else if (wr_ctrl_s) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
    if (wr_preset_s) begin
      preset_d = merge_bytes(preset_q, bus.din, bus.be);
    end else begin
      preset_d = preset_q;
    end
    irq_d = pend_d & im_d;
  end

  // Read mux, combinational from the word select.
  always_comb begin
    bus.dout = 32'd0;
    case (bus.addr)
      2'd0:    bus.dout = {27'd0, pend_q, im_q, mode_q, en_q};
      2'd1:    bus.dout = preset_q;
      2'd2:    bus.dout = count_q;
      default: bus.dout = 32'd0;
    endcase
  end

  assign bus.irq = irq_q;

  // State registers with synchronous reset that overrides any write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      mode_q   <= 2'b00;
      im_q     <= 1'b0;
      pend_q   <= 1'b0;
      irq_q    <= 1'b0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      pend_q   <= pend_d;
      irq_q    <= irq_d;
      preset_q <= preset_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: directed scenarios plus random bus traffic against a behavioural model.
module tb_timer_dev;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  timer_dev_if bus ();

  timer_dev u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: phase 0 idle, 1 load pending, 2 counting, 3 terminal cycle.
  int          m_ph;
  bit          m_en, m_im, m_pend;
  bit [1:0]    m_mode;
  bit [31:0]   m_preset, m_count;

  logic [31:0] rv;
  logic        iv;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_auto();
`ifdef TIMER_AUTORELOAD_EN
    return (m_mode == 2'b01);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit [31:0] m_read(input bit [1:0] a);
    case (a)
      2'd0:    return {27'd0, m_pend, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_step(input bit r, input bit w, input bit [1:0] a, input bit [3:0] b, input bit [31:0] d);
    bit        wc;
    bit        au;
    int        nph;
    bit [31:0] nc;
    if (r) begin
      m_ph = 0; m_en = 1'b0; m_im = 1'b0; m_pend = 1'b0; m_mode = 2'b00;
      m_preset = 32'd0; m_count = 32'd0;
      return;
    end
    wc  = w && (a == 2'd0) && b[0];
    au  = m_auto();
    nph = m_ph;
    nc  = m_count;
    if (m_ph == 0) begin
      if (m_en) nph = 1;
    end else if (m_ph == 1) begin
      nc = m_preset; nph = 2;
    end else if (m_ph == 2) begin
      if (!m_en) nph = 0;
      else if (m_count <= 32'd1) begin nc = 32'd0; nph = 3; end
      else nc = m_count - 32'd1;
    end else begin
      nph = au ? 1 : 0;
    end
    if (m_ph == 3) m_pend = 1'b1;
    else if (wc) m_pend = 1'b0;
    if (wc) begin
      m_en = d[0]; m_mode = d[2:1]; m_im = d[3];
    end else if (m_ph == 3 && !au) begin
      m_en = 1'b0;
    end
    if (w && a == 2'd1) begin
      for (int i = 0; i < 4; i++) if (b[i]) m_preset[8*i +: 8] = d[8*i +: 8];
    end
    m_ph    = nph;
    m_count = nc;
  endtask

  task automatic cyc(input bit r, input bit w, input bit [1:0] a, input bit [3:0] b, input bit [31:0] d,
                     output logic [31:0] rd, output logic irq_s);
    rst = r; bus.we = w; bus.addr = a; bus.be = b; bus.din = d;
    @(negedge clk);
    rd    = bus.dout;
    irq_s = bus.irq;
    check_eq("dout", rd, m_read(a));
    check_eq("irq", {31'd0, irq_s}, {31'd0, m_pend & m_im});
    @(posedge clk);
    m_step(r, w, a, b, d);
    #1;
  endtask

  task automatic wr(input bit [1:0] a, input bit [3:0] b, input bit [31:0] d);
    logic [31:0] x; logic y;
    cyc(1'b0, 1'b1, a, b, d, x, y);
  endtask

  initial begin
    logic [31:0] seq [0:9];
    logic        irqs [0:9];
    bit          r, w;
    bit [1:0]    a;
    bit [3:0]    b;
    bit [31:0]   d;

    rst = 1'b1; bus.we = 1'b0; bus.addr = 2'd0; bus.be = 4'd0; bus.din = 32'd0;
    @(posedge clk); m_step(1'b1, 1'b0, 2'd0, 4'd0, 32'd0); #1;
    @(posedge clk); #1;

    // Reset values on every address.
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 2'(k), 4'd0, 32'd0, rv, iv);
      check_eq("rst_read", rv, 32'd0);
      check_eq("rst_irq", {31'd0, iv}, 32'd0);
    end

    // Byte-enabled PRESET write, COUNT writes ignored.
    wr(2'd1, 4'b0001, 32'hFFFF_FFFF);
    cyc(1'b0, 1'b0, 2'd1, 4'd0, 32'd0, rv, iv);
    check_eq("preset_byte", rv, 32'h0000_00FF);
    wr(2'd2, 4'hF, 32'h1234_5678);
    wr(2'd3, 4'hF, 32'hFFFF_FFFF);
    cyc(1'b0, 1'b0, 2'd2, 4'd0, 32'd0, rv, iv);
    check_eq("count_ro", rv, 32'd0);

    // One-shot countdown from 5 with interrupt enabled.
    wr(2'd1, 4'hF, 32'd5);
    wr(2'd0, 4'hF, 32'h9);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b0, 2'd2, 4'd0, 32'd0, rv, iv);
      seq[k] = rv; irqs[k] = iv;
    end
    for (int k = 0; k < 6; k++) check_eq("oneshot_cnt", seq[k+2], 32'(5 - k));
    check_eq("oneshot_irq_lo", {31'd0, irqs[7]}, 32'd0);
    check_eq("oneshot_irq_hi", {31'd0, irqs[8]}, 32'd1);
    cyc(1'b0, 1'b0, 2'd0, 4'd0, 32'd0, rv, iv);
    check_eq("oneshot_ctrl", rv, 32'h18);

    // Masked interrupt: PEND without irq, then a CTRL write clears PEND.
    wr(2'd1, 4'hF, 32'd2);
    wr(2'd0, 4'hF, 32'h1);
    for (int k = 0; k < 8; k++) cyc(1'b0, 1'b0, 2'd2, 4'd0, 32'd0, rv, iv);
    cyc(1'b0, 1'b0, 2'd0, 4'd0, 32'd0, rv, iv);
    check_eq("masked_ctrl", rv, 32'h10);
    check_eq("masked_irq", {31'd0, iv}, 32'd0);
    wr(2'd0, 4'hF, 32'h8);
    cyc(1'b0, 1'b0, 2'd0, 4'd0, 32'd0, rv, iv);
    check_eq("clr_ctrl", rv, 32'h08);
    check_eq("clr_irq", {31'd0, iv}, 32'd0);

    // Disable while counting holds COUNT.
    wr(2'd1, 4'hF, 32'd100);
    wr(2'd0, 4'hF, 32'h1);
    cyc(1'b0, 1'b0, 2'd2, 4'd0, 32'd0, rv, iv);
    cyc(1'b0, 1'b0, 2'd2, 4'd0, 32'd0, rv, iv);
    cyc(1'b0, 1'b1, 2'd0, 4'hF, 32'h0, rv, iv);
    cyc(1'b0, 1'b0, 2'd2, 4'd0, 32'd0, rv, iv);
    check_eq("hold0", rv, 32'd99);
    cyc(1'b0, 1'b0, 2'd2, 4'd0, 32'd0, rv, iv);
    check_eq("hold1", rv, 32'd99);

    // Reset mid-count, colliding with a write.
    wr(2'd0, 4'hF, 32'h9);
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 2'd2, 4'd0, 32'd0, rv, iv);
    cyc(1'b1, 1'b1, 2'd1, 4'hF, 32'hAB, rv, iv);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 2'(k), 4'd0, 32'd0, rv, iv);
      check_eq("midrst", rv, 32'd0);
    end

    // CTRL write during the terminal cycle: EN written wins, PEND survives the clear.
    wr(2'd1, 4'hF, 32'd2);
    wr(2'd0, 4'hF, 32'h9);
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 2'd2, 4'd0, 32'd0, rv, iv);
    wr(2'd0, 4'hF, 32'h9);
    cyc(1'b0, 1'b0, 2'd0, 4'd0, 32'd0, rv, iv);
    check_eq("int_race_ctrl", rv, 32'h19);
    wr(2'd0, 4'hF, 32'h0);

    // MODE=01 with PRESET=3: reloads when the feature is built in, one-shot otherwise.
    wr(2'd1, 4'hF, 32'd3);
    wr(2'd0, 4'hF, 32'hB);
    for (int k = 0; k < 16; k++) cyc(1'b0, 1'b0, 2'd2, 4'd0, 32'd0, rv, iv);
    wr(2'd0, 4'hF, 32'hB);
    cyc(1'b0, 1'b0, 2'd0, 4'd0, 32'd0, rv, iv);
    check_eq("reload_clr_irq", {31'd0, iv}, 32'd0);
    for (int k = 0; k < 8; k++) cyc(1'b0, 1'b0, 2'd2, 4'd0, 32'd0, rv, iv);
    wr(2'd0, 4'hF, 32'h0);

    // Random bus traffic.
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 199) == 0);
      w = ($urandom_range(0, 5) == 0);
      a = 2'($urandom_range(0, 3));
      b = 4'($urandom_range(0, 15));
      d = $urandom;
      if (a == 2'd1 && $urandom_range(0, 3) != 0) begin
        b = 4'hF;
        d = 32'($urandom_range(0, 7));
      end
      cyc(r, w, a, b, d, rv, iv);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
